// File: rtl/bist_pkg.sv
// Shared types and helpers for the RAM BIST read-back path.
package bist_pkg;

  localparam int BIST_ADDR_W   = 10;
  localparam int BIST_DATA_W   = 8;
  localparam int BIST_WORD_MAX = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } bist_state_e;

  // Callers truncate the result to their own data width.
  function automatic logic [BIST_WORD_MAX-1:0] bist_exp_word(
    input logic [BIST_WORD_MAX-1:0] seed,
    input logic                     inv
  );
    bist_exp_word = inv ? ~seed : seed;
  endfunction

endpackage

// File: rtl/bist_rd_tag_pipe.sv
// RD_LAT-deep delay line of {valid, addr} tags that tracks reads in flight to the RAM.
module bist_rd_tag_pipe
  import bist_pkg::*;
#(
  parameter int ADDR_W = BIST_ADDR_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic              pending
);

  logic [RD_LAT-1:0] vld_r;
  logic [ADDR_W-1:0] addr_r [RD_LAT];
  logic              pending_s;

  // Tag shift register; flush drops every tag still in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_r <= '0;
      for (int i = 0; i < RD_LAT; i++) addr_r[i] <= '0;
    end else if (flush) begin
      vld_r <= '0;
      for (int i = 0; i < RD_LAT; i++) addr_r[i] <= '0;
    end else begin
      vld_r[0]  <= in_valid;
      addr_r[0] <= in_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_r[i]  <= vld_r[i-1];
        addr_r[i] <= addr_r[i-1];
      end
    end
  end

  // Tags still behind the output stage; the output stage itself is consumed this cycle.
  always_comb begin
    pending_s = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) pending_s = pending_s | vld_r[i];
  end

  assign out_valid = vld_r[RD_LAT-1];
  assign out_addr  = addr_r[RD_LAT-1];
  assign pending   = pending_s;

endmodule

// File: rtl/bist_readback_checker.sv
// RAM BIST read-back checker: sweeps all addresses, compares against the data background.
// Optional macro BIST_STOP_ON_FAIL_EN ends the sweep right after the first mismatch.
module bist_readback_checker
  import bist_pkg::*;
#(
  parameter int ADDR_W = BIST_ADDR_W,
  parameter int DATA_W = BIST_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] pattern_seed,
  input  logic              invert,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic [DATA_W-1:0] first_fail_data
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   ERR_MAX   = '1;
  localparam logic [ADDR_W:0]   ERR_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  bist_state_e       state_r, state_nx;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] exp_r;
  logic [ADDR_W:0]   err_cnt_r, err_cnt_nx;
  logic [ADDR_W-1:0] ff_addr_r;
  logic [DATA_W-1:0] ff_data_r;
  logic              rd_en_r, busy_r, done_r, pass_r, fail_r;
  logic              accept_s, stop_s, mism_s;
  logic              tag_valid_s, pending_s;
  logic [ADDR_W-1:0] tag_addr_s;
  logic [DATA_W-1:0] seed_exp_s;

  bist_rd_tag_pipe #(
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .flush     (stop_s),
    .in_valid  (rd_en_r),
    .in_addr   (addr_r),
    .out_valid (tag_valid_s),
    .out_addr  (tag_addr_s),
    .pending   (pending_s)
  );

  assign accept_s   = (state_r == IDLE) && start;
  assign seed_exp_s = DATA_W'(bist_exp_word(BIST_WORD_MAX'(pattern_seed), invert));

  // Early termination: a nonzero registered count mid-sweep means the first miss has landed.
  always_comb begin
    stop_s = 1'b0;
`ifdef BIST_STOP_ON_FAIL_EN
    if ((state_r == READ) || (state_r == DRAIN)) begin
      stop_s = (err_cnt_r != '0);
    end else begin
      stop_s = 1'b0;
    end
`endif
  end

  // Compare the returning word and step the saturating mismatch counter.
  always_comb begin
    mism_s     = 1'b0;
    err_cnt_nx = err_cnt_r;
    if (tag_valid_s && !stop_s && (rd_data != exp_r)) begin
      mism_s = 1'b1;
      if (err_cnt_r != ERR_MAX) begin
        err_cnt_nx = err_cnt_r + ERR_ONE;
      end else begin
        err_cnt_nx = err_cnt_r;
      end
    end else begin
      mism_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nx = READ;
        else       state_nx = IDLE;
      end
      READ: begin
        if (stop_s)                  state_nx = DONE;
        else if (addr_r == ADDR_LAST) state_nx = DRAIN;
        else                         state_nx = READ;
      end
      DRAIN: begin
        if (stop_s || !pending_s) state_nx = DONE;
        else                      state_nx = DRAIN;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, handshake outputs, address counter and result capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      addr_r    <= '0;
      exp_r     <= '0;
      err_cnt_r <= '0;
      ff_addr_r <= '0;
      ff_data_r <= '0;
      rd_en_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
      fail_r    <= 1'b0;
    end else begin
      state_r <= state_nx;
      rd_en_r <= (state_nx == READ);
      busy_r  <= (state_nx != IDLE);
      done_r  <= (state_nx == DONE);
      if (accept_s) begin
        exp_r     <= seed_exp_s;
        addr_r    <= '0;
        err_cnt_r <= '0;
        ff_addr_r <= '0;
        ff_data_r <= '0;
        pass_r    <= 1'b0;
        fail_r    <= 1'b0;
      end else begin
        if (state_r == READ) addr_r <= addr_r + ADDR_ONE;
        err_cnt_r <= err_cnt_nx;
        if (mism_s && (err_cnt_r == '0)) begin
          ff_addr_r <= tag_addr_s;
          ff_data_r <= rd_data;
        end
        // Use the next count so a miss on the final in-flight word is included.
        if (state_nx == DONE) begin
          pass_r <= (err_cnt_nx == '0);
          fail_r <= (err_cnt_nx != '0);
        end
      end
    end
  end

  assign rd_en           = rd_en_r;
  assign rd_addr         = addr_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign pass            = pass_r;
  assign fail            = fail_r;
  assign err_count       = err_cnt_r;
  assign first_fail_addr = ff_addr_r;
  assign first_fail_data = ff_data_r;

endmodule

// File: tb/tb_bist_readback_checker.sv
// Bench for bist_readback_checker: one instance with RD_LAT=1, one with RD_LAT=3, shared RAM image.
module tb_bist_readback_checker;

`ifdef BIST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start_v [2];
  logic [7:0] seed_v  [2];
  logic       inv_v   [2];
  logic       rd_en_v [2];
  logic [9:0] rd_addr_v [2];
  logic [7:0] rd_data_v [2];
  logic       busy_v [2];
  logic       done_v [2];
  logic       pass_v [2];
  logic       fail_v [2];
  logic [10:0] err_v [2];
  logic [9:0] ffa_v [2];
  logic [7:0] ffd_v [2];

  logic [7:0] mem [1024];
  logic [7:0] dl [2][4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bist_readback_checker #(.ADDR_W(10), .DATA_W(8), .RD_LAT(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .pattern_seed(seed_v[0]), .invert(inv_v[0]),
    .rd_en(rd_en_v[0]), .rd_addr(rd_addr_v[0]), .rd_data(rd_data_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .fail(fail_v[0]),
    .err_count(err_v[0]), .first_fail_addr(ffa_v[0]), .first_fail_data(ffd_v[0]));

  bist_readback_checker #(.ADDR_W(10), .DATA_W(8), .RD_LAT(3)) u_dut_l3 (
    .clk(clk), .rst(rst), .start(start_v[1]), .pattern_seed(seed_v[1]), .invert(inv_v[1]),
    .rd_en(rd_en_v[1]), .rd_addr(rd_addr_v[1]), .rd_data(rd_data_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .fail(fail_v[1]),
    .err_count(err_v[1]), .first_fail_addr(ffa_v[1]), .first_fail_data(ffd_v[1]));

  // Behavioural RAM read ports with 1- and 3-cycle latency; idle reads return a junk word.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int k = 3; k > 0; k--) dl[i][k] <= dl[i][k-1];
      dl[i][0] <= rd_en_v[i] ? mem[rd_addr_v[i]] : 8'hEE;
    end
  end
  assign rd_data_v[0] = dl[0][0];
  assign rd_data_v[1] = dl[1][2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic fill(input logic [7:0] bg);
    for (int a = 0; a < 1024; a++) mem[a] = bg;
  endtask

  // Reference: scan the RAM image, then apply the timing rules for the sweep.
  task automatic model(input logic [7:0] e, input int lat_rd, output int err, output int ffa,
                       output int ffd, output int lat);
    int first;
    first = -1; err = 0; ffa = 0; ffd = 0;
    for (int a = 0; a < 1024; a++) begin
      if (mem[a] != e) begin
        if (first < 0) begin
          first = a; ffa = a; ffd = int'(mem[a]);
        end
        err++;
      end
    end
    lat = 1024 + lat_rd + 1;
    if (STOP && first >= 0) begin
      err = 1;
      if (first + lat_rd + 3 < lat) lat = first + lat_rd + 3;
    end
  endtask

  task automatic run_sweep(input int inst, input logic [7:0] seed, input logic inv, input bit dbl,
                           output int lat, output int ndone, output int nrd, output int oerr,
                           output int busy_bad);
    lat = -1; ndone = 0; nrd = 0; oerr = 0; busy_bad = 0;
    @(negedge clk);
    start_v[inst] = 1'b1; seed_v[inst] = seed; inv_v[inst] = inv;
    for (int k = 1; k < 1200; k++) begin
      @(negedge clk);
      start_v[inst] = dbl && (k == 5);
      seed_v[inst]  = ~seed;
      inv_v[inst]   = ~inv;
      if (rd_en_v[inst]) begin
        if (rd_addr_v[inst] != 10'(nrd)) oerr++;
        nrd++;
      end
      if (done_v[inst]) begin
        ndone++;
        if (lat < 0) lat = k;
      end
      if (lat < 0 && busy_v[inst] !== 1'b1) busy_bad++;
      if (lat >= 0 && k > lat && busy_v[inst] !== 1'b0) busy_bad++;
      if (lat >= 0 && k == lat + 3) break;
    end
  endtask

  typedef struct {
    int         inst;
    logic [7:0] bg;
    int         nf;
    logic [9:0] fa0;
    logic [7:0] fd0;
    logic [9:0] fa1;
    logic [7:0] fd1;
    logic [7:0] seed;
    logic       inv;
    bit         dbl;
    logic       exp_pass;
    int         exp_err;
    logic [9:0] exp_ffa;
    logic [7:0] exp_ffd;
    int         exp_lat;
  } vec_t;

  vec_t tbl [7];

  task automatic check_run(input string tag, input int inst, input logic e_pass, input int e_err,
                           input int e_ffa, input int e_ffd, input int e_lat, input int lat,
                           input int ndone, input int nrd, input int oerr, input int busy_bad);
    chk({tag, "_lat"}, lat, e_lat);
    chk({tag, "_ndone"}, ndone, 1);
    chk({tag, "_order"}, oerr, 0);
    chk({tag, "_busy"}, busy_bad, 0);
    chk({tag, "_pass"}, pass_v[inst], e_pass);
    chk({tag, "_fail"}, fail_v[inst], !e_pass);
    chk({tag, "_err"}, err_v[inst], e_err);
    chk({tag, "_ffa"}, ffa_v[inst], e_ffa);
    chk({tag, "_ffd"}, ffd_v[inst], e_ffd);
`ifndef BIST_STOP_ON_FAIL_EN
    chk({tag, "_nrd"}, nrd, 1024);
`endif
  endtask

  initial begin
    int lat, ndone, nrd, oerr, bb;
    int m_err, m_ffa, m_ffd, m_lat;
    int inst, nf, cyc_done, cyc_busy;
    logic [7:0] bg, sd;
    logic iv, found;

    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0; seed_v[i] = 8'h00; inv_v[i] = 1'b0;
    end
    fill(8'hA5);
    #3;
    for (int i = 0; i < 2; i++)
      chk($sformatf("reset_outs%0d", i),
          {busy_v[i], done_v[i], pass_v[i], fail_v[i], err_v[i], ffa_v[i], ffd_v[i],
           rd_en_v[i], rd_addr_v[i]}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    tbl[0] = '{0, 8'hA5, 0, 10'h000, 8'h00, 10'h000, 8'h00, 8'hA5, 1'b0, 1'b0,
               1'b1, 0, 10'h000, 8'h00, 1026};
    tbl[1] = '{0, 8'hA5, 0, 10'h000, 8'h00, 10'h000, 8'h00, 8'h5A, 1'b1, 1'b0,
               1'b1, 0, 10'h000, 8'h00, 1026};
    tbl[2] = '{0, 8'hA5, 2, 10'h07F, 8'hA4, 10'h3FF, 8'h00, 8'hA5, 1'b0, 1'b0,
               1'b0, STOP ? 1 : 2, 10'h07F, 8'hA4, STOP ? 131 : 1026};
    tbl[3] = '{1, 8'hA5, 0, 10'h000, 8'h00, 10'h000, 8'h00, 8'hA5, 1'b0, 1'b1,
               1'b1, 0, 10'h000, 8'h00, 1028};
    tbl[4] = '{1, 8'hA5, 1, 10'h3FF, 8'h00, 10'h000, 8'h00, 8'hA5, 1'b0, 1'b0,
               1'b0, 1, 10'h3FF, 8'h00, 1028};
    tbl[5] = '{0, 8'h3C, 1, 10'h000, 8'hFF, 10'h000, 8'h00, 8'h3C, 1'b0, 1'b0,
               1'b0, 1, 10'h000, 8'hFF, STOP ? 4 : 1026};
    tbl[6] = '{0, 8'h3C, 0, 10'h000, 8'h00, 10'h000, 8'h00, 8'hC3, 1'b1, 1'b0,
               1'b1, 0, 10'h000, 8'h00, 1026};

    for (int t = 0; t < 7; t++) begin
      fill(tbl[t].bg);
      if (tbl[t].nf > 0) mem[tbl[t].fa0] = tbl[t].fd0;
      if (tbl[t].nf > 1) mem[tbl[t].fa1] = tbl[t].fd1;
      run_sweep(tbl[t].inst, tbl[t].seed, tbl[t].inv, tbl[t].dbl, lat, ndone, nrd, oerr, bb);
      check_run($sformatf("vec%0d", t), tbl[t].inst, tbl[t].exp_pass, tbl[t].exp_err,
                int'(tbl[t].exp_ffa), int'(tbl[t].exp_ffd), tbl[t].exp_lat,
                lat, ndone, nrd, oerr, bb);
    end

    // Randomized backgrounds and fault sets against the reference scan.
    for (int r = 0; r < 4; r++) begin
      inst = int'($urandom_range(0, 1));
      bg   = 8'($urandom);
      iv   = 1'($urandom);
      sd   = iv ? ~bg : bg;
      fill(bg);
      nf = int'($urandom_range(0, 3));
      for (int f = 0; f < nf; f++) mem[10'($urandom)] = 8'($urandom);
      model(bg, inst ? 3 : 1, m_err, m_ffa, m_ffd, m_lat);
      run_sweep(inst, sd, iv, 1'b0, lat, ndone, nrd, oerr, bb);
      check_run($sformatf("rnd%0d", r), inst, m_err == 0, m_err, m_ffa, m_ffd, m_lat,
                lat, ndone, nrd, oerr, bb);
    end

    // Reset in the middle of a sweep.
    fill(8'h5C);
    @(negedge clk);
    start_v[0] = 1'b1; seed_v[0] = 8'h5C; inv_v[0] = 1'b0;
    @(negedge clk);
    start_v[0] = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 1100 && !found; k++) begin
      if (rd_en_v[0] && rd_addr_v[0] == 10'h200) found = 1'b1;
      else @(negedge clk);
    end
    chk("rst_reach_addr", found, 1'b1);
    rst = 1'b0;
    #1;
    chk("rst_mid_outs",
        {busy_v[0], done_v[0], pass_v[0], fail_v[0], err_v[0], ffa_v[0], ffd_v[0],
         rd_en_v[0], rd_addr_v[0]}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cyc_done = 0; cyc_busy = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done_v[0]) cyc_done++;
      if (busy_v[0]) cyc_busy++;
    end
    chk("rst_no_done", cyc_done, 0);
    chk("rst_no_busy", cyc_busy, 0);
    model(8'h5C, 1, m_err, m_ffa, m_ffd, m_lat);
    run_sweep(0, 8'h5C, 1'b0, 1'b0, lat, ndone, nrd, oerr, bb);
    check_run("post_rst", 0, m_err == 0, m_err, m_ffa, m_ffd, m_lat, lat, ndone, nrd, oerr, bb);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
